// File: rtl/medfilt_sched.sv
// Shares one median-filter core between NCH sample streams. Each accepted sample
// triggers a full replay of that channel's WINDOW-deep history into the core.
module medfilt_sched #(
    parameter int NCH     = 4,
    parameter int WIDTH   = 8,
    parameter int WINDOW  = 5,
    parameter int TIMEOUT = 64,
    localparam int CW     = $clog2(NCH)
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [NCH*WIDTH-1:0] in_x,
    input  logic [NCH-1:0]       in_valid,
    output logic [NCH-1:0]       in_ready,
    output logic [WIDTH-1:0]     core_x,
    output logic                 core_dvi,
    input  logic [WIDTH-1:0]     core_med,
    input  logic                 core_dvo,
    output logic [WIDTH-1:0]     out_med,
    output logic [CW-1:0]        out_ch,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 err_timeout
);

    localparam int FW = $clog2(WINDOW + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {S_IDLE, S_FEED, S_WAIT, S_DONE} state_t;

    state_t                                   state_q, state_d;
    logic [CW-1:0]                            ptr_q, ptr_d;
    logic [CW-1:0]                            ch_q, ch_d;
    logic [FW-1:0]                            feed_idx_q, feed_idx_d;
    logic [FW-1:0]                            dvo_cnt_q, dvo_cnt_d;
    logic [TW-1:0]                            timer_q, timer_d;
    logic [WIDTH-1:0]                         out_med_q, out_med_d;
    logic [CW-1:0]                            out_ch_q, out_ch_d;
    logic                                     err_q, err_d;
    // Index 0 is the oldest sample, WINDOW-1 the newest.
    logic [NCH-1:0][WINDOW-1:0][WIDTH-1:0]    hist_q, hist_d;

    logic [NCH-1:0][WIDTH-1:0]                in_x_v;
    logic                                     grant_vld;
    logic [CW-1:0]                            grant_ch;
    logic                                     final_dvo;

    assign in_x_v = in_x;

    // Round-robin search starting at the pointer, wrapping modulo NCH.
    always_comb begin
        grant_vld = 1'b0;
        grant_ch  = '0;
        for (int i = 0; i < NCH; i++) begin
            if (!grant_vld && in_valid[(int'(ptr_q) + i) % NCH]) begin
                grant_vld = 1'b1;
                grant_ch  = CW'((int'(ptr_q) + i) % NCH);
            end
        end
    end

    // Reset gating keeps the grant low while reset is held, even with requests pending.
    assign in_ready    = (state_q == S_IDLE && grant_vld && reset) ? (NCH'(1) << grant_ch) : '0;
    assign core_dvi    = (state_q == S_FEED);
    assign core_x      = (state_q == S_FEED) ? hist_q[ch_q][feed_idx_q] : '0;
    assign out_valid   = (state_q == S_DONE);
    assign out_med     = out_med_q;
    assign out_ch      = out_ch_q;
    assign err_timeout = err_q;

    assign final_dvo = core_dvo && (dvo_cnt_q == FW'(WINDOW - 1)) &&
                       (state_q == S_FEED || state_q == S_WAIT);

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        ch_d       = ch_q;
        feed_idx_d = feed_idx_q;
        dvo_cnt_d  = dvo_cnt_q;
        timer_d    = timer_q;
        out_med_d  = out_med_q;
        out_ch_d   = out_ch_q;
        err_d      = err_q;
        hist_d     = hist_q;
        case (state_q)
            S_IDLE: begin
                if (grant_vld) begin
                    for (int i = 0; i < WINDOW - 1; i++)
                        hist_d[grant_ch][i] = hist_q[grant_ch][i + 1];
                    hist_d[grant_ch][WINDOW-1] = in_x_v[grant_ch];
                    ch_d       = grant_ch;
                    ptr_d      = (grant_ch == CW'(NCH - 1)) ? '0 : grant_ch + 1'b1;
                    feed_idx_d = '0;
                    dvo_cnt_d  = '0;
                    state_d    = S_FEED;
                end
            end
            S_FEED: begin
                if (core_dvo) dvo_cnt_d = dvo_cnt_q + 1'b1;
                // A zero-latency core delivers the last median during the final feed cycle.
                if (final_dvo) begin
                    out_med_d = core_med;
                    out_ch_d  = ch_q;
                    state_d   = S_DONE;
                end else if (feed_idx_q == FW'(WINDOW - 1)) begin
                    timer_d = '0;
                    state_d = S_WAIT;
                end else begin
                    feed_idx_d = feed_idx_q + 1'b1;
                end
            end
            S_WAIT: begin
                if (core_dvo) dvo_cnt_d = dvo_cnt_q + 1'b1;
                if (final_dvo) begin
                    out_med_d = core_med;
                    out_ch_d  = ch_q;
                    state_d   = S_DONE;
                end else if (timer_q == TW'(TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            S_DONE: begin
                if (out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            ptr_q      <= '0;
            ch_q       <= '0;
            feed_idx_q <= '0;
            dvo_cnt_q  <= '0;
            timer_q    <= '0;
            out_med_q  <= '0;
            out_ch_q   <= '0;
            err_q      <= 1'b0;
            hist_q     <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            ch_q       <= ch_d;
            feed_idx_q <= feed_idx_d;
            dvo_cnt_q  <= dvo_cnt_d;
            timer_q    <= timer_d;
            out_med_q  <= out_med_d;
            out_ch_q   <= out_ch_d;
            err_q      <= err_d;
            hist_q     <= hist_d;
        end
    end

endmodule

// File: tb/tb_medfilt_sched.sv
// Bench for medfilt_sched: behavioural median core with selectable latency,
// per-channel history model and a result scoreboard.
module tb_medfilt_sched;
    localparam int NCH = 4, WIDTH = 8, WINDOW = 5, TIMEOUT = 64, CW = 2;

    logic                  clock = 1'b0;
    logic                  reset = 1'b0;
    logic [NCH*WIDTH-1:0]  in_x;
    logic [NCH-1:0]        in_valid, in_ready;
    logic [WIDTH-1:0]      core_x, core_med, out_med;
    logic                  core_dvi, core_dvo, out_valid, out_ready, err_timeout;
    logic [CW-1:0]         out_ch;

    medfilt_sched #(.NCH(NCH), .WIDTH(WIDTH), .WINDOW(WINDOW), .TIMEOUT(TIMEOUT)) dut (
        .clock(clock), .reset(reset), .in_x(in_x), .in_valid(in_valid), .in_ready(in_ready),
        .core_x(core_x), .core_dvi(core_dvi), .core_med(core_med), .core_dvo(core_dvo),
        .out_med(out_med), .out_ch(out_ch), .out_valid(out_valid), .out_ready(out_ready),
        .err_timeout(err_timeout));

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int total = 0, bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // ---------------- behavioural median core ----------------
    int                               lat = 0;
    bit                               dvo_en = 1'b1;
    logic [WINDOW-1:0][WIDTH-1:0]     cwin = '0;
    logic [WINDOW-1:0][WIDTH-1:0]     nwin;
    logic [WIDTH-1:0]                 med0;
    logic [7:0]                       pv = '0;
    logic [7:0][WIDTH-1:0]            pm = '0;

    function automatic logic [WIDTH-1:0] sort_median(input logic [WINDOW-1:0][WIDTH-1:0] w);
        logic [WIDTH-1:0] a [WINDOW];
        logic [WIDTH-1:0] t;
        for (int i = 0; i < WINDOW; i++) a[i] = w[i];
        for (int i = 0; i < WINDOW; i++)
            for (int j = 0; j < WINDOW - 1 - i; j++)
                if (a[j] > a[j+1]) begin t = a[j]; a[j] = a[j+1]; a[j+1] = t; end
        return a[WINDOW/2];
    endfunction

    always_comb begin
        nwin = {cwin[WINDOW-2:0], core_x};
        med0 = sort_median(nwin);
    end

    always @(posedge clock) begin
        if (core_dvi) cwin <= nwin;
        pv <= {pv[6:0], core_dvi & dvo_en};
        pm <= {pm[6:0], med0};
    end

    assign core_dvo = (lat == 0) ? (core_dvi & dvo_en) : pv[lat-1];
    assign core_med = (lat == 0) ? med0 : pm[lat-1];

    // ---------------- reference model + scoreboard ----------------
    typedef struct packed {
        logic [CW-1:0]    ch;
        logic [WIDTH-1:0] med;
    } exp_t;

    exp_t                                 sb[$];
    exp_t                                 e;
    logic [NCH-1:0][WINDOW-1:0][WIDTH-1:0] mh;
    int                                   mptr = 0;
    bit                                   no_result = 1'b0;
    logic [NCH-1:0]                       eg;

    // Median by rank: the element with at most WINDOW/2 values strictly below and above.
    function automatic logic [WIDTH-1:0] ref_median(input logic [WINDOW-1:0][WIDTH-1:0] h);
        int lt, gt;
        for (int i = 0; i < WINDOW; i++) begin
            lt = 0; gt = 0;
            for (int j = 0; j < WINDOW; j++) begin
                if (h[j] < h[i]) lt++;
                if (h[j] > h[i]) gt++;
            end
            if (lt <= WINDOW/2 && gt <= WINDOW/2) return h[i];
        end
        return '0;
    endfunction

    function automatic logic [NCH-1:0] rr_expect(input logic [NCH-1:0] v, input int p);
        logic [NCH-1:0] r;
        bit found;
        r = '0; found = 0;
        for (int i = 0; i < NCH; i++)
            if (!found && v[(p + i) % NCH]) begin r[(p + i) % NCH] = 1'b1; found = 1; end
        return r;
    endfunction

    initial begin
        mh = '0;
        forever begin
            @(negedge clock);
            if (!reset) begin
                sb.delete();
                mh   = '0;
                mptr = 0;
            end else begin
                if (|in_ready) begin
                    eg = rr_expect(in_valid, mptr);
                    chk("grant", 32'(in_ready), 32'(eg));
                end
                for (int c = 0; c < NCH; c++) begin
                    if (in_valid[c] && in_ready[c]) begin
                        mh[c] = {mh[c][WINDOW-2:0], in_x[c*WIDTH +: WIDTH]};
                        if (!no_result) sb.push_back('{ch: CW'(c), med: ref_median(mh[c])});
                        mptr = (c + 1) % NCH;
                    end
                end
                if (out_valid && out_ready) begin
                    if (sb.size() == 0) begin
                        total++; bad++;
                        $display("FAIL unexpected_result: got med %0h ch %0d expected none", out_med, out_ch);
                    end else begin
                        e = sb.pop_front();
                        chk("out_med", 32'(out_med), 32'(e.med));
                        chk("out_ch", 32'(out_ch), 32'(e.ch));
                    end
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic send(input int c, input logic [WIDTH-1:0] v, output int k);
        @(posedge clock); #1;
        in_valid = '0;
        in_valid[c] = 1'b1;
        in_x[c*WIDTH +: WIDTH] = v;
        k = -1;
        for (int n = 0; n < 300; n++) begin
            @(negedge clock);
            if (in_ready[c]) begin k = cyc; break; end
        end
        if (k < 0) begin
            total++; bad++;
            $display("FAIL send_grant: got no grant for ch%0d expected a grant", c);
        end
        @(posedge clock); #1;
        in_valid = '0;
    endtask

    task automatic wait_valid(output int m);
        m = -1;
        for (int n = 0; n < 300; n++) begin
            @(negedge clock);
            if (out_valid) begin m = cyc; break; end
        end
        if (m < 0) begin
            total++; bad++;
            $display("FAIL wait_valid: got out_valid=0 expected 1 within bound");
        end
    endtask

    task automatic drain();
        bit ok;
        ok = 0;
        for (int n = 0; n < 600; n++) begin
            @(negedge clock);
            if (sb.size() == 0 && !out_valid) begin ok = 1; break; end
        end
        if (!ok) begin
            total++; bad++;
            $display("FAIL drain: got %0d pending expected 0", sb.size());
        end
    endtask

    // exp lists the fed samples first-to-last from its MSB downwards.
    task automatic feed_chk(input int k, input logic [WINDOW-1:0][WIDTH-1:0] exp,
                            input logic [WIDTH-1:0] emed);
        int m;
        for (int i = 0; i < WINDOW; i++) begin
            @(negedge clock);
            chk("feed_dvi", 32'(core_dvi), 32'd1);
            chk("feed_x", 32'(core_x), 32'(exp[WINDOW-1-i]));
        end
        wait_valid(m);
        chk("latency", 32'(m - k), 32'(WINDOW + lat + 1));
        chk("done_dvi", 32'(core_dvi), 32'd0);
        chk("direct_med", 32'(out_med), 32'(emed));
        @(posedge clock); #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    // ---------------- test sequence ----------------
    initial begin
        int k, m;
        logic [WIDTH-1:0] held;
        bit got;
        in_valid = '0; in_x = '0; out_ready = 1'b1;

        // 1: reset state, with requests pending
        repeat (3) @(posedge clock);
        #2 in_valid = '1;
        @(negedge clock);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_med", 32'(out_med), 32'd0);
        chk("rst_out_ch", 32'(out_ch), 32'd0);
        chk("rst_core_dvi", 32'(core_dvi), 32'd0);
        chk("rst_core_x", 32'(core_x), 32'd0);
        chk("rst_err", 32'(err_timeout), 32'd0);
        in_valid = '0;
        @(posedge clock); #3 reset = 1'b1;

        send(0, 8'd10, k); feed_chk(k, {8'd0, 8'd0, 8'd0, 8'd0, 8'd10}, 8'd0);
        chk("t1_ch", 32'(out_ch), 32'd0);
        // 2: history builds up on ch0
        send(0, 8'd50, k); feed_chk(k, {8'd0, 8'd0, 8'd0, 8'd10, 8'd50}, 8'd0);
        send(0, 8'd30, k); feed_chk(k, {8'd0, 8'd0, 8'd10, 8'd50, 8'd30}, 8'd10);
        send(0, 8'd20, k); feed_chk(k, {8'd0, 8'd10, 8'd50, 8'd30, 8'd20}, 8'd20);
        send(0, 8'd40, k); feed_chk(k, {8'd10, 8'd50, 8'd30, 8'd20, 8'd40}, 8'd30);

        // 3: all channels requesting from ptr=0
        @(posedge clock); #2 reset = 1'b0;
        @(negedge clock);
        @(posedge clock); #2 reset = 1'b1;
        @(posedge clock); #1;
        for (int c = 0; c < NCH; c++) in_x[c*WIDTH +: WIDTH] = WIDTH'($urandom);
        in_valid = '1;
        for (int r = 0; r < 5; r++) begin
            got = 0;
            for (int n = 0; n < 100; n++) begin
                @(negedge clock);
                if (|in_ready) begin got = 1; break; end
            end
            chk("rr_order", 32'(in_ready), 32'd1 << (r % NCH));
            if (got) begin
                @(posedge clock); #1;
                in_x[(r % NCH)*WIDTH +: WIDTH] = WIDTH'($urandom);
            end
        end
        @(posedge clock); #1 in_valid = '0;
        drain();

        // 4: consumer stall in DONE
        @(posedge clock); #1 out_ready = 1'b0;
        send(1, WIDTH'($urandom), k);
        wait_valid(m);
        held = out_med;
        @(posedge clock); #1 in_valid = '1;
        for (int n = 0; n < 10; n++) begin
            @(negedge clock);
            chk("hold_valid", 32'(out_valid), 32'd1);
            chk("hold_med", 32'(out_med), 32'(held));
            chk("hold_in_ready", 32'(in_ready), 32'd0);
            chk("hold_dvi", 32'(core_dvi), 32'd0);
        end
        @(posedge clock); #1 in_valid = '0; out_ready = 1'b1;
        drain();

        // 5: core never answers
        @(posedge clock); #1 dvo_en = 1'b0; no_result = 1'b1;
        send(1, WIDTH'($urandom), k);
        while (cyc < k + WINDOW + TIMEOUT) @(negedge clock);
        chk("err_before", 32'(err_timeout), 32'd0);
        @(negedge clock);
        chk("err_after", 32'(err_timeout), 32'd1);
        chk("timeout_no_valid", 32'(out_valid), 32'd0);
        @(posedge clock); #1 dvo_en = 1'b1; no_result = 1'b0;
        send(1, WIDTH'($urandom), k);
        wait_valid(m);
        chk("err_sticky", 32'(err_timeout), 32'd1);
        drain();

        // 6: reset in the third FEED cycle
        send(3, 8'd99, k);
        @(posedge clock); @(posedge clock); #2;
        chk("feed_active", 32'(core_dvi), 32'd1);
        in_valid[2] = 1'b1; in_x[2*WIDTH +: WIDTH] = 8'd7;
        reset = 1'b0; #1;
        chk("arst_dvi", 32'(core_dvi), 32'd0);
        chk("arst_x", 32'(core_x), 32'd0);
        chk("arst_in_ready", 32'(in_ready), 32'd0);
        chk("arst_valid", 32'(out_valid), 32'd0);
        chk("arst_err", 32'(err_timeout), 32'd0);
        chk("arst_med", 32'(out_med), 32'd0);
        chk("arst_ch", 32'(out_ch), 32'd0);
        @(negedge clock);
        in_valid = '0;
        @(posedge clock); #2 reset = 1'b1;
        send(2, 8'd7, k);
        wait_valid(m);
        chk("post_rst_med", 32'(out_med), 32'd0);
        chk("post_rst_ch", 32'(out_ch), 32'd2);
        drain();

        // 7: random traffic at several core latencies
        foreach (pv[i]) begin end
        for (int ph = 0; ph < 3; ph++) begin
            repeat (10) @(posedge clock);
            #1 lat = (ph == 0) ? 1 : (ph == 1) ? 3 : 0;
            for (int n = 0; n < 150; n++) begin
                @(posedge clock); #1;
                in_valid  = NCH'($urandom);
                in_x      = (NCH*WIDTH)'($urandom);
                out_ready = ($urandom_range(0, 3) != 0);
            end
            @(posedge clock); #1 in_valid = '0; out_ready = 1'b1;
            drain();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
